bin2bcd_seq: RTL

//  Sequential double-dabble binary-to-BCD converter with valid/ready handshakes on both sides.

---
 rtl/bin2bcd_seq_pkg.sv | 12 +
 rtl/bcd_dabble_digit.sv | 11 +
 rtl/bin2bcd_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// rtl/bin2bcd_seq_pkg.sv - shared FSM encodings and BCD correction constants
package bin2bcd_seq_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [3:0] BCD_CORR   = 4'd3;
    localparam logic [3:0] BCD_THRESH = 4'd5;

endpackage

// File: rtl/bcd_dabble_digit.sv
// rtl/bcd_dabble_digit.sv - add-3 correction of one BCD digit ahead of a double-dabble shift
module bcd_dabble_digit
    import bin2bcd_seq_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= BCD_THRESH) ? (din + BCD_CORR) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter with valid/ready on both sides
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_WIDTH   = 16,
    parameter int DIGITS      = 5,
    parameter int SIGNED_MODE = 0,
    parameter int NDIG_W      = 3
) (
    input  logic                  sclk,
    input  logic                  s_rst,
    input  logic                  bin_vld,
    output logic                  bin_rdy,
    input  logic [BIN_WIDTH-1:0]  bin_data,
    output logic                  bcd_vld,
    input  logic                  bcd_rdy,
    output logic [4*DIGITS-1:0]   bcd_data,
    output logic                  bcd_sign,
    output logic [NDIG_W-1:0]     bcd_ndig,
    output logic                  bcd_ovf
);

    localparam int CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0]    shreg_q, shreg_d;
    logic [4*DIGITS-1:0]     digits_q, digits_d;
    logic                    ovf_q, ovf_d;
    logic                    sign_q, sign_d;
    logic                    bcd_vld_q, bcd_vld_d;
    logic [4*DIGITS-1:0]     bcd_data_q, bcd_data_d;
    logic                    bcd_sign_q, bcd_sign_d;
    logic [NDIG_W-1:0]       bcd_ndig_q, bcd_ndig_d;
    logic                    bcd_ovf_q, bcd_ovf_d;

    logic [4*DIGITS-1:0]     corr;
    logic                    bin_neg;
    logic [BIN_WIDTH-1:0]    bin_mag;
    logic [NDIG_W-1:0]       ndig;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_dabble_digit u_digit (
            .din  (digits_q[4*g +: 4]),
            .dout (corr[4*g +: 4])
        );
    end

    // Negating the most-negative value wraps to itself, which reads correctly as unsigned.
    assign bin_neg = (SIGNED_MODE != 0) && bin_data[BIN_WIDTH-1];
    assign bin_mag = bin_neg ? -bin_data : bin_data;

    always_comb begin
        ndig = NDIG_W'(1);
        for (int i = 1; i < DIGITS; i++) begin
            if (digits_q[4*i +: 4] != 4'd0) begin
                ndig = NDIG_W'(i + 1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        digits_d   = digits_q;
        ovf_d      = ovf_q;
        sign_d     = sign_q;
        bcd_vld_d  = bcd_vld_q;
        bcd_data_d = bcd_data_q;
        bcd_sign_d = bcd_sign_q;
        bcd_ndig_d = bcd_ndig_q;
        bcd_ovf_d  = bcd_ovf_q;
        case (state_q)
            IDLE: begin
                if (bin_vld) begin
                    shreg_d  = bin_mag;
                    sign_d   = bin_neg;
                    digits_d = '0;
                    cnt_d    = CNT_W'(BIN_WIDTH - 1);
                    ovf_d    = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // A set top bit would be shifted out: the value no longer fits in DIGITS.
                {digits_d, shreg_d} = {corr[4*DIGITS-2:0], shreg_q, 1'b0};
                if (corr[4*DIGITS-1]) begin
                    ovf_d = 1'b1;
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                bcd_data_d = digits_q;
                bcd_sign_d = sign_q;
                bcd_ndig_d = ndig;
                bcd_ovf_d  = ovf_q;
                bcd_vld_d  = 1'b1;
                state_d    = DONE;
            end
            default: begin
                if (bcd_rdy) begin
                    bcd_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            digits_q   <= '0;
            ovf_q      <= 1'b0;
            sign_q     <= 1'b0;
            bcd_vld_q  <= 1'b0;
            bcd_data_q <= '0;
            bcd_sign_q <= 1'b0;
            bcd_ndig_q <= NDIG_W'(1);
            bcd_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            digits_q   <= digits_d;
            ovf_q      <= ovf_d;
            sign_q     <= sign_d;
            bcd_vld_q  <= bcd_vld_d;
            bcd_data_q <= bcd_data_d;
            bcd_sign_q <= bcd_sign_d;
            bcd_ndig_q <= bcd_ndig_d;
            bcd_ovf_q  <= bcd_ovf_d;
        end
    end

    assign bin_rdy  = (state_q == IDLE);
    assign bcd_vld  = bcd_vld_q;
    assign bcd_data = bcd_data_q;
    assign bcd_sign = bcd_sign_q;
    assign bcd_ndig = bcd_ndig_q;
    assign bcd_ovf  = bcd_ovf_q;

endmodule
